smu_dribbler: RTL and testbench
===============================

SMU_DRIBBLER -- requirements
Module: smu_dribbler

Interface
REQ-001 Parameters SHALL be: DEPTH, default 64, stack-cache entries (power of two, 8..256). IDXW, default log2(DEPTH), register-file index width. BURST, default 4, maximum back-to-back spill/fill operations per episode (1..15).
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 optop_in  in  32  new optop byte address. optop_we  in  1  write strobe for optop_in.
REQ-005 sbase_in  in  32  IU stack-base write value. sbase_we  in  1  write strobe for sbase_in.
REQ-006 dre  in  1  dribbler enable. int_abort  in  1  interrupt abort. flush  in  1  IU hazard flush.
REQ-007 low_mark, high_mark  in  IDXW  fill and spill watermarks.
REQ-008 smu_ld, smu_st  out  1  dcache load and store requests. smu_addr  out  32  request address. smu_data  out  32  store data.
REQ-009 dcu_stall  in  1  dcache not accepting. dcu_data_vld  in  1  load data valid. dcu_data  in  32  load data.
REQ-010 smu_rf_addr  out  IDXW  register-file index. smu_we  out  1  register-file write. smu_rf_din  out  32  register-file write data. iu_rf_dout  in  32  register-file read data.
REQ-011 smu_sbase  out  32  current stack base. smu_sbase_we  out  1  stack-base update pulse. smu_hold  out  1  stall IU pipe.

Function
REQ-012 Cached entries SHALL occupy word addresses optop_r+4 .. sbase_r.
REQ-013 E = (sbase_r - optop_r)>>2 SHALL be computed as a 30-bit value. optop_r and sbase_r are word-aligned registers; bits [1:0] of the inputs are ignored.
REQ-014 FSM states SHALL be IDLE, SPILL, FILL_REQ, FILL_WAIT and DRAIN.
REQ-015 IDLE SHALL go to SPILL when dre & E>high_mark & !int_abort, else to FILL_REQ when dre & E<low_mark & !int_abort; spill has priority when both conditions hold.
REQ-016 SPILL SHALL assert smu_st with smu_addr=sbase_r, smu_data=iu_rf_dout and smu_rf_addr=sbase_r[IDXW+1:2]; these outputs stay stable while dcu_stall=1.
REQ-017 On spill acceptance (smu_st & !dcu_stall), sbase_r SHALL decrement by 4 and smu_sbase_we SHALL pulse for one cycle.
REQ-018 FILL_REQ SHALL assert smu_ld with smu_addr=sbase_r+4, held while dcu_stall=1; on acceptance the FSM goes to FILL_WAIT.
REQ-019 In FILL_WAIT, a cycle with dcu_data_vld SHALL produce smu_we=1, smu_rf_din=dcu_data and smu_rf_addr=(sbase_r+4)[IDXW+1:2], then sbase_r+=4 and smu_sbase_we pulses.
REQ-020 After each completed operation the FSM SHALL re-evaluate REQ-015 directly, except after BURST consecutive operations, when it returns to IDLE for at least one cycle.
REQ-021 While int_abort=1, the FSM SHALL complete any accepted operation, then remain in IDLE and issue no new request; a SPILL or FILL_REQ request not yet accepted is withdrawn.
REQ-022 flush or sbase_we in FILL_WAIT SHALL move the FSM to DRAIN. DRAIN consumes the next dcu_data_vld without smu_we and without changing sbase_r, then goes to IDLE.
REQ-023 flush in IDLE, SPILL or FILL_REQ SHALL withdraw any unaccepted request and go to IDLE.
REQ-024 sbase_we SHALL load sbase_r=sbase_in and take priority over a same-cycle dribbler update, which is then discarded; smu_sbase_we does not pulse for IU writes.
REQ-025 optop_we SHALL update optop_r in the same cycle as any dribbler sbase update; both take effect.
REQ-026 smu_hold SHALL be combinational and equal dre & (E >= DEPTH-1).
REQ-027 When dre=0, no new request SHALL start; an accepted operation completes.
REQ-028 smu_ld and smu_st SHALL never both be 1, and at most one load SHALL be outstanding.

Reset
REQ-029 On reset: sbase_r=0, optop_r=0, burst count=0, state IDLE. smu_ld, smu_st, smu_we, smu_sbase_we, smu_addr, smu_data, smu_rf_addr and smu_rf_din = 0.
REQ-030 Reset mid-operation SHALL abandon the operation; load data arriving after reset is ignored.

Verification
REQ-031 Spill (DEPTH=64, BURST=4, high=48, low=8): sbase=0x1000, optop=0x0F38 (E=50) -> st 0x1000 rf_addr 0, then st 0x0FFC rf_addr 63; smu_sbase=0x0FF8; then idle.
REQ-032 Fill: sbase=0x1000, optop=0x0FEC (E=5), vld data 0xDEADBEEF -> ld 0x1004, smu_we rf_addr 1 din 0xDEADBEEF; three fills total end at sbase=0x100C.
REQ-033 Stall: dcu_stall held 3 cycles during the first spill -> smu_st, smu_addr and smu_data constant, sbase unchanged until the release cycle.
REQ-034 Flush: flush in FILL_WAIT, then vld -> no smu_we, sbase unchanged, FSM in IDLE afterwards.
REQ-035 Burst and hold: E=63 -> smu_hold=1; 4 spills, one IDLE cycle, then spills resume; smu_hold drops when E=62.
REQ-036 Reset in FILL_WAIT, then vld -> no smu_we; all outputs 0.

Source files
------------

// File: rtl/smu_dribbler.sv
// Stack-cache dribbler: spills the entry at sbase when occupancy rises above high_mark, and fills from sbase+4 when it falls below low_mark.
// Requests are combinational from state and held while dcu_stall=1; fill data is written to the register file the cycle dcu_data_vld arrives.
module smu_dribbler #(
  parameter int DEPTH = 64,
  parameter int IDXW  = $clog2(DEPTH),
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     optop_in,
  input  logic            optop_we,
  input  logic [31:0]     sbase_in,
  input  logic            sbase_we,
  input  logic            dre,
  input  logic            int_abort,
  input  logic            flush,
  input  logic [IDXW-1:0] low_mark,
  input  logic [IDXW-1:0] high_mark,
  output logic            smu_ld,
  output logic            smu_st,
  output logic [31:0]     smu_addr,
  output logic [31:0]     smu_data,
  input  logic            dcu_stall,
  input  logic            dcu_data_vld,
  input  logic [31:0]     dcu_data,
  output logic [IDXW-1:0] smu_rf_addr,
  output logic            smu_we,
  output logic [31:0]     smu_rf_din,
  input  logic [31:0]     iu_rf_dout,
  output logic [31:0]     smu_sbase,
  output logic            smu_sbase_we,
  output logic            smu_hold
);

  typedef enum logic [2:0] {IDLE, SPILL, FILL_REQ, FILL_WAIT, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] sbase_r, optop_r, sbase_nxt, optop_nxt, fill_addr;
  logic [31:0] diff, diff_nxt;
  logic [29:0] ent, ent_nxt, hi_w, lo_w;
  logic [3:0]  burst_cnt;
  logic        req_ok, start_ok, spill_acc, fill_done, op_done, burst_last;
  logic        unused_bits;

  function automatic state_t pick(input logic ok, input logic [29:0] e,
                                  input logic [29:0] hi, input logic [29:0] lo);
    if (ok && e > hi) return SPILL;
    if (ok && e < lo) return FILL_REQ;
    return IDLE;
  endfunction

  assign fill_addr  = sbase_r + 32'd4;
  assign diff       = sbase_r - optop_r;
  assign ent        = diff[31:2];
  assign hi_w       = 30'(high_mark);
  assign lo_w       = 30'(low_mark);
  assign req_ok     = !int_abort && !flush;
  assign start_ok   = dre && req_ok;
  assign spill_acc  = (state == SPILL) && req_ok && !dcu_stall;
  assign fill_done  = (state == FILL_WAIT) && dcu_data_vld && !flush && !sbase_we;
  assign op_done    = spill_acc || fill_done;
  assign burst_last = (burst_cnt == 4'(BURST - 1));

  // IU writes win over a same-cycle dribbler step; optop updates independently.
  always_comb begin
    sbase_nxt = sbase_r;
    if (sbase_we)       sbase_nxt = {sbase_in[31:2], 2'b00};
    else if (spill_acc) sbase_nxt = sbase_r - 32'd4;
    else if (fill_done) sbase_nxt = fill_addr;
  end

  assign optop_nxt = optop_we ? {optop_in[31:2], 2'b00} : optop_r;
  assign diff_nxt  = sbase_nxt - optop_nxt;
  assign ent_nxt   = diff_nxt[31:2];

  assign smu_sbase   = sbase_r;
  assign smu_hold    = dre && (ent >= 30'(DEPTH - 1));
  assign unused_bits = ^{sbase_in[1:0], optop_in[1:0], diff[1:0], diff_nxt[1:0]};

  always_comb begin
    state_nxt   = state;
    smu_st      = 1'b0;
    smu_ld      = 1'b0;
    smu_addr    = 32'd0;
    smu_data    = 32'd0;
    smu_rf_addr = '0;
    smu_we      = 1'b0;
    smu_rf_din  = 32'd0;
    case (state)
      IDLE: state_nxt = pick(start_ok, ent, hi_w, lo_w);
      SPILL: begin
        if (!req_ok) state_nxt = IDLE;
        else begin
          smu_st      = 1'b1;
          smu_addr    = sbase_r;
          smu_data    = iu_rf_dout;
          smu_rf_addr = sbase_r[IDXW+1:2];
        end
      end
      FILL_REQ: begin
        if (!req_ok) state_nxt = IDLE;
        else begin
          smu_ld      = 1'b1;
          smu_addr    = fill_addr;
          smu_rf_addr = fill_addr[IDXW+1:2];
          if (!dcu_stall) state_nxt = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        smu_rf_addr = fill_addr[IDXW+1:2];
        // Data arriving together with the flush is simply dropped.
        if (flush || sbase_we) state_nxt = dcu_data_vld ? IDLE : DRAIN;
        else if (dcu_data_vld) begin
          smu_we     = 1'b1;
          smu_rf_din = dcu_data;
        end
      end
      DRAIN: if (dcu_data_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (op_done) state_nxt = burst_last ? IDLE : pick(start_ok, ent_nxt, hi_w, lo_w);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sbase_r      <= 32'd0;
      optop_r      <= 32'd0;
      burst_cnt    <= 4'd0;
      smu_sbase_we <= 1'b0;
    end else begin
      state        <= state_nxt;
      sbase_r      <= sbase_nxt;
      optop_r      <= optop_nxt;
      smu_sbase_we <= op_done && !sbase_we;
      if (state_nxt == IDLE) burst_cnt <= 4'd0;
      else if (op_done)      burst_cnt <= burst_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_smu_dribbler.sv
// Bench for smu_dribbler: request/write scoreboard plus vector table and hand sequences.
module tb_smu_dribbler;

  logic        clk = 1'b0;
  logic        reset, optop_we, sbase_we, dre, int_abort, flush;
  logic [31:0] optop_in, sbase_in;
  logic [5:0]  low_mark, high_mark;
  logic        smu_ld, smu_st, smu_we, smu_sbase_we, smu_hold;
  logic [31:0] smu_addr, smu_data, smu_rf_din, smu_sbase, iu_rf_dout, dcu_data;
  logic [5:0]  smu_rf_addr;
  logic        dcu_stall, dcu_data_vld;
  logic        resp_en, resp_vld, man_vld;
  logic [31:0] resp_data, man_data;

  always #5 clk = ~clk;

  assign iu_rf_dout   = 32'hC0DE_0000 | {26'd0, smu_rf_addr};
  assign dcu_data_vld = resp_vld | man_vld;
  assign dcu_data     = man_vld ? man_data : resp_data;

  smu_dribbler dut (
    .clk(clk), .reset(reset), .optop_in(optop_in), .optop_we(optop_we),
    .sbase_in(sbase_in), .sbase_we(sbase_we), .dre(dre), .int_abort(int_abort),
    .flush(flush), .low_mark(low_mark), .high_mark(high_mark), .smu_ld(smu_ld),
    .smu_st(smu_st), .smu_addr(smu_addr), .smu_data(smu_data), .dcu_stall(dcu_stall),
    .dcu_data_vld(dcu_data_vld), .dcu_data(dcu_data), .smu_rf_addr(smu_rf_addr),
    .smu_we(smu_we), .smu_rf_din(smu_rf_din), .iu_rf_dout(iu_rf_dout),
    .smu_sbase(smu_sbase), .smu_sbase_we(smu_sbase_we), .smu_hold(smu_hold)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [5:0]  rf;
    logic [31:0] dat;
  } ev_t;
  localparam logic [1:0] K_ST = 2'd1, K_LD = 2'd2, K_WE = 2'd3;

  typedef struct {
    logic [31:0] sb;
    logic [31:0] op;
    logic        en;
    logic        hold;
  } hvec_t;

  ev_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_pulse = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic got(input ev_t ev);
    ev_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h rf=%0d dat=%h, expected none",
               ev.kind, ev.addr, ev.rf, ev.dat);
    end else begin
      e = sb_q.pop_front();
      if (e !== ev) begin
        n_bad++;
        $display("FAIL sb_event: got kind=%0d addr=%h rf=%0d dat=%h, expected kind=%0d addr=%h rf=%0d dat=%h",
                 ev.kind, ev.addr, ev.rf, ev.dat, e.kind, e.addr, e.rf, e.dat);
      end
    end
  endtask

  function automatic ev_t ev_st(input logic [31:0] a);
    return {K_ST, a, a[7:2], 32'hC0DE_0000 | {26'd0, a[7:2]}};
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h1004) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // Monitor: every accepted request and register-file write is matched against the queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (smu_st && !dcu_stall) got(ev_st(smu_addr) & '0 | {K_ST, smu_addr, smu_rf_addr, smu_data});
      if (smu_ld && !dcu_stall) got({K_LD, smu_addr, 6'd0, 32'd0});
      if (smu_we) got({K_WE, 32'd0, smu_rf_addr, smu_rf_din});
      if (smu_sbase_we) n_pulse++;
      if (smu_st && smu_ld) chk("st_ld_exclusive", 32'(smu_st & smu_ld), 32'd0);
    end
  end

  // Memory model: answers each accepted load two cycles later.
  initial begin
    logic [31:0] a;
    resp_vld = 1'b0;
    resp_data = 32'd0;
    forever begin
      @(negedge clk);
      if (resp_en && smu_ld && !dcu_stall && !reset) begin
        a = smu_addr;
        @(posedge clk);
        @(posedge clk);
        #1 resp_vld = 1'b1;
        resp_data = mem_val(a);
        @(posedge clk);
        #1 resp_vld = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    dre = 1'b0; flush = 1'b0; int_abort = 1'b0; dcu_stall = 1'b0;
    sbase_we = 1'b0; optop_we = 1'b0; man_vld = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_regs(input logic [31:0] s, input logic [31:0] o);
    sbase_in = s; optop_in = o; sbase_we = 1'b1; optop_we = 1'b1;
    tick();
    sbase_we = 1'b0; optop_we = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({"drain_", tag}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    tick(2);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ld"}, 32'(smu_ld), 32'd0);
    chk({tag, "_st"}, 32'(smu_st), 32'd0);
    chk({tag, "_we"}, 32'(smu_we), 32'd0);
    chk({tag, "_sbase_we"}, 32'(smu_sbase_we), 32'd0);
    chk({tag, "_addr"}, smu_addr, 32'd0);
    chk({tag, "_data"}, smu_data, 32'd0);
    chk({tag, "_rf_addr"}, 32'(smu_rf_addr), 32'd0);
    chk({tag, "_rf_din"}, smu_rf_din, 32'd0);
    chk({tag, "_sbase"}, smu_sbase, 32'd0);
  endtask

  initial begin
    hvec_t hv[8];
    int p0;
    hv[0] = '{32'h1000, 32'h0F04, 1'b1, 1'b1};
    hv[1] = '{32'h1000, 32'h0F08, 1'b1, 1'b0};
    hv[2] = '{32'h1000, 32'h0F04, 1'b0, 1'b0};
    hv[3] = '{32'h1000, 32'h0F00, 1'b1, 1'b1};
    hv[4] = '{32'h0000, 32'hFFFF_FF04, 1'b1, 1'b1};
    hv[5] = '{32'h1003, 32'h0F07, 1'b1, 1'b1};
    hv[6] = '{32'h1000, 32'h1000, 1'b1, 1'b0};
    hv[7] = '{32'h2000, 32'h1000, 1'b1, 1'b1};

    optop_in = 32'd0; sbase_in = 32'd0; resp_en = 1'b0; man_data = 32'd0;
    low_mark = 6'd8; high_mark = 6'd48;
    do_reset();
    reset = 1'b1;
    tick();
    check_idle_outputs("reset");
    chk("reset_hold", 32'(smu_hold), 32'd0);
    reset = 1'b0;

    // Occupancy/hold table, dre only pulsed between edges so nothing starts.
    for (int i = 0; i < 8; i++) begin
      set_regs(hv[i].sb, hv[i].op);
      dre = hv[i].en;
      #1;
      chk($sformatf("hold_vec%0d", i), 32'(smu_hold), 32'(hv[i].hold));
      chk($sformatf("sbase_vec%0d", i), smu_sbase, hv[i].sb & 32'hFFFF_FFFC);
      chk($sformatf("st_vec%0d", i), 32'(smu_st), 32'd0);
      dre = 1'b0;
    end

    // Two spills from E=50 down to the high mark.
    do_reset();
    set_regs(32'h1000, 32'h0F38);
    p0 = n_pulse;
    sb_q.push_back(ev_st(32'h1000));
    sb_q.push_back(ev_st(32'h0FFC));
    dre = 1'b1;
    wait_drain("spill", 20);
    chk("spill_sbase", smu_sbase, 32'h0FF8);
    chk("spill_pulses", 32'(n_pulse - p0), 32'd2);
    tick(3);
    chk("spill_idle_st", 32'(smu_st), 32'd0);
    chk("spill_idle_ld", 32'(smu_ld), 32'd0);

    // Stall on the first spill: request frozen, sbase unchanged.
    do_reset();
    set_regs(32'h1000, 32'h0F38);
    sb_q.push_back(ev_st(32'h1000));
    sb_q.push_back(ev_st(32'h0FFC));
    dcu_stall = 1'b1;
    dre = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d_st", i), 32'(smu_st), 32'd1);
      chk($sformatf("stall%0d_addr", i), smu_addr, 32'h1000);
      chk($sformatf("stall%0d_data", i), smu_data, 32'hC0DE_0000);
      chk($sformatf("stall%0d_sbase", i), smu_sbase, 32'h1000);
      tick();
    end
    dcu_stall = 1'b0;
    #1;
    chk("stall_release_sbase", smu_sbase, 32'h1000);
    wait_drain("stall", 20);
    chk("stall_sbase_end", smu_sbase, 32'h0FF8);

    // Three fills from E=5 up to the low mark.
    do_reset();
    set_regs(32'h1000, 32'h0FEC);
    resp_en = 1'b1;
    p0 = n_pulse;
    sb_q.push_back({K_LD, 32'h1004, 6'd0, 32'd0});
    sb_q.push_back({K_WE, 32'd0, 6'd1, 32'hDEAD_BEEF});
    sb_q.push_back({K_LD, 32'h1008, 6'd0, 32'd0});
    sb_q.push_back({K_WE, 32'd0, 6'd2, mem_val(32'h1008)});
    sb_q.push_back({K_LD, 32'h100C, 6'd0, 32'd0});
    sb_q.push_back({K_WE, 32'd0, 6'd3, mem_val(32'h100C)});
    dre = 1'b1;
    wait_drain("fill", 60);
    chk("fill_sbase", smu_sbase, 32'h100C);
    chk("fill_pulses", 32'(n_pulse - p0), 32'd3);
    dre = 1'b0;
    resp_en = 1'b0;

    // Abort withdraws a stalled spill and holds the FSM idle.
    do_reset();
    set_regs(32'h1000, 32'h0F38);
    dcu_stall = 1'b1;
    dre = 1'b1;
    tick();
    chk("abort_pre_st", 32'(smu_st), 32'd1);
    int_abort = 1'b1;
    dcu_stall = 1'b0;
    #1;
    chk("abort_st_withdrawn", 32'(smu_st), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort%0d_req", i), 32'(smu_st | smu_ld), 32'd0);
      chk($sformatf("abort%0d_sbase", i), smu_sbase, 32'h1000);
    end
    sb_q.push_back(ev_st(32'h1000));
    sb_q.push_back(ev_st(32'h0FFC));
    int_abort = 1'b0;
    wait_drain("abort", 20);
    chk("abort_sbase_end", smu_sbase, 32'h0FF8);

    // Burst limit and hold from E=63: groups of 4 spills separated by one idle cycle.
    do_reset();
    set_regs(32'h1000, 32'h0F04);
    p0 = n_pulse;
    for (int i = 0; i < 15; i++) sb_q.push_back(ev_st(32'h1000 - 32'(4 * i)));
    dre = 1'b1;
    #1;
    for (int c = 0; c < 23; c++) begin
      chk($sformatf("burst_c%0d_st", c), 32'(smu_st), 32'((c % 5 != 0) && (c <= 18)));
      chk($sformatf("burst_c%0d_hold", c), 32'(smu_hold), 32'(c <= 1));
      tick();
    end
    wait_drain("burst", 10);
    chk("burst_sbase", smu_sbase, 32'h0FC4);
    chk("burst_pulses", 32'(n_pulse - p0), 32'd15);

    // Flush during FILL_WAIT: late data is drained, no write, sbase kept.
    do_reset();
    set_regs(32'h1000, 32'h0FEC);
    p0 = n_pulse;
    sb_q.push_back({K_LD, 32'h1004, 6'd0, 32'd0});
    dre = 1'b1;
    tick();
    chk("flush_ld", 32'(smu_ld), 32'd1);
    tick();
    chk("flush_wait_ld", 32'(smu_ld), 32'd0);
    flush = 1'b1;
    dre = 1'b0;
    tick();
    flush = 1'b0;
    tick();
    man_vld = 1'b1;
    man_data = 32'h1234_5678;
    #1;
    chk("flush_vld_we", 32'(smu_we), 32'd0);
    tick();
    man_vld = 1'b0;
    tick();
    chk("flush_sbase", smu_sbase, 32'h1000);
    chk("flush_pulses", 32'(n_pulse - p0), 32'd0);
    sb_q.push_back({K_LD, 32'h1004, 6'd0, 32'd0});
    dre = 1'b1;
    wait_drain("flush_restart", 10);

    // The restarted fill now sits in FILL_WAIT: reset it, then deliver data.
    dre = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    man_vld = 1'b1;
    man_data = 32'hBAD0_BAD0;
    #1;
    check_idle_outputs("rst_vld");
    tick();
    man_vld = 1'b0;
    tick();
    check_idle_outputs("rst_after");
    chk("rst_queue", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
